// File: rtl/alu_cmd_issue_if.sv
// Bundle of the command, ALU-drive and response signals of alu_cmd_issue.
// slave = the issue block, master = upstream/ALU/response side.
interface alu_cmd_issue_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_a;
  logic [7:0]    cmd_b;
  logic          cmd_cin;
  logic [2:0]    cmd_sel;

  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic          alu_cin;
  logic [2:0]    alu_sel;
  logic [15:0]   alu_result;
  logic          alu_carry;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [15:0]   rsp_result;
  logic          rsp_carry;
  logic [2:0]    rsp_sel;
  logic          rsp_err;

  logic [CW-1:0] fifo_count;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_sel, alu_result, alu_carry, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_cin, alu_sel,
    input  rsp_valid, rsp_result, rsp_carry, rsp_sel, rsp_err, fifo_count
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_sel, alu_result, alu_carry, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_cin, alu_sel,
    output rsp_valid, rsp_result, rsp_carry, rsp_sel, rsp_err, fifo_count
  );
endinterface

// File: rtl/alu_cmd_issue.sv
// Command FIFO feeding a registered alu_8bit drive, one response per command.
// Optional macro ALU_CMD_ISSUE_ILLEGAL_OP_CHECK_EN flags sel=3'b111 as illegal.
module alu_cmd_issue #(
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  alu_cmd_issue_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [2:0] sel;
  } cmd_t;

  cmd_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  cmd_t          alu_cmd_q, alu_cmd_d;
  logic [15:0]   rsp_result_q, rsp_result_d;
  logic          rsp_carry_q, rsp_carry_d;
  logic [2:0]    rsp_sel_q, rsp_sel_d;
  logic          rsp_valid_q, rsp_valid_d;
`ifdef ALU_CMD_ISSUE_ILLEGAL_OP_CHECK_EN
  logic          rsp_err_q, rsp_err_d;
`endif

  logic full, push, pop;
  cmd_t head, push_cmd;

  // Readiness and pop both look only at registered occupancy, so a command
  // written this edge cannot be popped until the next one.
  always_comb begin
    full     = (count_q == CW'(FIFO_DEPTH));
    push     = bus.cmd_valid && !full;
    pop      = (count_q != '0) &&
               ((state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready));
    head     = mem_q[rd_ptr_q];
    push_cmd = {bus.cmd_a, bus.cmd_b, bus.cmd_cin, bus.cmd_sel};
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    alu_cmd_d    = alu_cmd_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_sel_d    = rsp_sel_q;
    rsp_valid_d  = rsp_valid_q;
`ifdef ALU_CMD_ISSUE_ILLEGAL_OP_CHECK_EN
    rsp_err_d    = rsp_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          alu_cmd_d = head;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        rsp_result_d = bus.alu_result;
        rsp_carry_d  = bus.alu_carry;
        rsp_sel_d    = alu_cmd_q.sel;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
`ifdef ALU_CMD_ISSUE_ILLEGAL_OP_CHECK_EN
        rsp_err_d    = 1'b0;
        if (alu_cmd_q.sel == 3'b111) begin
          rsp_result_d = 16'h0000;
          rsp_carry_d  = 1'b0;
          rsp_err_d    = 1'b1;
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (pop) begin
            alu_cmd_d = head;
            state_d   = ISSUE;
          end else begin
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= push_cmd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      alu_cmd_q    <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_sel_q    <= '0;
      rsp_valid_q  <= 1'b0;
`ifdef ALU_CMD_ISSUE_ILLEGAL_OP_CHECK_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      alu_cmd_q    <= alu_cmd_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_sel_q    <= rsp_sel_d;
      rsp_valid_q  <= rsp_valid_d;
`ifdef ALU_CMD_ISSUE_ILLEGAL_OP_CHECK_EN
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign bus.cmd_ready  = !full;
  assign bus.fifo_count = count_q;
  assign bus.alu_a      = alu_cmd_q.a;
  assign bus.alu_b      = alu_cmd_q.b;
  assign bus.alu_cin    = alu_cmd_q.cin;
  assign bus.alu_sel    = alu_cmd_q.sel;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_sel    = rsp_sel_q;
`ifdef ALU_CMD_ISSUE_ILLEGAL_OP_CHECK_EN
  assign bus.rsp_err    = rsp_err_q;
`else
  assign bus.rsp_err    = 1'b0;
`endif
endmodule

// File: doc/alu_cmd_issue.md
ALU_CMD_ISSUE -- requirements
Module: alu_cmd_issue

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, command FIFO entries; SHALL be a power of two, 2..16.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 cmd_valid  input  1  upstream command present.
REQ-006 cmd_ready  output  1  command FIFO can accept.
REQ-007 cmd_a, cmd_b  input  8 each  operands.
REQ-008 cmd_cin  input  1  carry-in; cmd_sel  input  3  ALU opcode.
REQ-009 alu_a, alu_b  output  8 each; alu_cin  output  1; alu_sel  output  3  registered drive to the downstream alu_8bit.
REQ-010 alu_result  input  16; alu_carry  input  1  combinational ALU outputs.
REQ-011 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-012 rsp_result  output  16; rsp_carry  output  1; rsp_sel  output  3  opcode echo; rsp_err  output  1  illegal-opcode flag.
REQ-013 fifo_count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 Push: command written to FIFO tail on a rising edge with cmd_valid && cmd_ready.
REQ-015 cmd_ready SHALL equal !full, derived from registered count only; no combinational dependence on pop.
REQ-016 FIFO SHALL NOT bypass: a command pushed at edge N is poppable no earlier than edge N+1.
REQ-017 FSM states: IDLE, ISSUE, RESP.
REQ-018 IDLE: if count>0, pop head into alu_a/alu_b/alu_cin/alu_sel registers and go ISSUE; else stay.
REQ-019 ISSUE: ALU inputs held stable one full cycle; at the edge ending ISSUE, capture alu_result, alu_carry, alu_sel into rsp_* registers, set rsp_valid=1, go RESP.
REQ-020 RESP: rsp_* held constant while rsp_valid && !rsp_ready.
REQ-021 RESP with rsp_ready=1: rsp_valid clears at that edge; if count>0 pop next command into ALU registers and go ISSUE in the same edge, else go IDLE.
REQ-022 Latency: command pushed at edge N into empty idle block -> rsp_valid high after edge N+2; sustained throughput one command per 2 cycles.
REQ-023 alu_* registers retain last popped command until the next pop.
REQ-024 Simultaneous push and pop in one edge: count unchanged, both operations take effect.
REQ-025 Full FIFO: cmd_ready=0; cmd_valid ignored, no overwrite.
REQ-026 Pointers wrap modulo FIFO_DEPTH without loss or duplication.
REQ-027 rsp_err=0 for all commands unless REQ-033 applies.

Reset
REQ-028 rst at a rising edge: FSM->IDLE, FIFO emptied, fifo_count=0, cmd_ready=1.
REQ-029 rst clears alu_a, alu_b, alu_cin, alu_sel, rsp_result, rsp_carry, rsp_sel, rsp_err, rsp_valid to 0.
REQ-030 Reset mid-operation discards queued and in-flight commands; no response issued for them.
REQ-031 rst overrides push and pop in the same cycle.

Configuration
REQ-032 Macro ALU_CMD_ISSUE_ILLEGAL_OP_CHECK_EN selects opcode-legality checking.
REQ-033 Defined: a command with sel=3'b111 SHALL pass through IDLE/ISSUE/RESP with normal timing but respond rsp_result=16'h0000, rsp_carry=0, rsp_err=1, rsp_sel=3'b111.
REQ-034 Undefined: rsp_err SHALL be tied 0 and sel=3'b111 SHALL be captured from the ALU like any other opcode.

Verification
REQ-035 Single op: after reset push a=8'h01,b=8'h00,cin=0,sel=000 at edge N, rsp_ready=1 -> rsp_valid after edge N+2, rsp_result=16'h0001, rsp_sel=000.
REQ-036 Back-to-back: push 3 commands (sel=000 1+0; sel=010 3*3; sel=001 1-0), rsp_ready=1 -> responses in order 16'h0001, 16'h0009, 16'h0001, spaced 2 cycles apart.
REQ-037 Backpressure/full: rsp_ready=0, push FIFO_DEPTH+2 commands -> cmd_ready falls after FIFO_DEPTH+1 accepts (FIFO full plus one in flight); rsp_* held stable; releasing rsp_ready drains all accepted in order, none lost.
REQ-038 Wrap and concurrent push/pop: stream 10 commands with rsp_ready toggling every cycle -> all 10 responses correct, in order; fifo_count never exceeds FIFO_DEPTH.
REQ-039 Reset mid-operation: assert rst while in RESP with 2 queued -> next cycle rsp_valid=0, fifo_count=0, cmd_ready=1, all alu_* outputs 0, no further responses.
REQ-040 Illegal op (macro defined): push sel=111 -> rsp_err=1, rsp_result=16'h0000; macro undefined -> rsp_err=0, rsp_result equals ALU output.
